trace_grader: RTL and testbench

TRACE_GRADER -- requirements
Module: trace_grader

---
 rtl/trace_grader_if.sv | 27 ++
 rtl/trace_grader.sv | 156 +++++++++++++++
 tb/tb_trace_grader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/trace_grader_if.sv
// Trace ROM and cache-under-test read bus seen by trace_grader.
// Parameterised to match the grader's ADDR_W / DATA_W.
interface trace_grader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    // Handshake: the grader raises dut_rreq with a stable dut_raddr and keeps both
    // until the cache answers with dut_rvalid=1 (dut_rdata valid on that same cycle);
    // dut_rvalid is ignored whenever dut_rreq is low. trace_rdata follows trace_addr
    // after exactly one clock.
    logic [ADDR_W-1:0] trace_addr;
    logic [DATA_W-1:0] trace_rdata;
    logic              dut_rreq;
    logic [ADDR_W-1:0] dut_raddr;
    logic [DATA_W-1:0] dut_rdata;
    logic              dut_rvalid;

    modport master (
        output trace_addr, dut_rreq, dut_raddr,
        input  trace_rdata, dut_rdata, dut_rvalid
    );

    modport slave (
        input  trace_addr, dut_rreq, dut_raddr,
        output trace_rdata, dut_rdata, dut_rvalid
    );
endinterface

// File: rtl/trace_grader.sv
// Walks an address range, compares cache read data against a golden trace ROM and
// reports pass/fail, run cycles and worst latency. Optional macro: GRADER_TIMEOUT_EN.
module trace_grader #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    trace_grader_if.master    bus,
    output logic              busy,
    output logic              test_success,
    output logic              test_fail,
    output logic              fail_timeout,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_expected,
    output logic [DATA_W-1:0] fail_actual,
    output logic [31:0]       count,
    output logic [15:0]       max_latency,
    output logic [2:0]        dbg_state
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] READ_TRACE = 3'd1;
    localparam logic [2:0] READ_CACHE = 3'd2;
    localparam logic [2:0] COMPARE    = 3'd3;
    localparam logic [2:0] PASS       = 3'd4;
    localparam logic [2:0] FAIL       = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] expected;
    logic [DATA_W-1:0] actual;
    logic [15:0]       wait_cnt;
    logic [15:0]       latency;
    logic              start_ok;

    assign start_ok = start && !busy;

    // Latency is the number of request cycles before the answering one, floored at 1,
    // so a cache answering on the first request cycle and one a cycle later both read 1.
    assign latency = (wait_cnt == 16'd0) ? 16'd1 : wait_cnt;

    always_comb begin
        busy           = (state == READ_TRACE) || (state == READ_CACHE) || (state == COMPARE);
        test_success   = (state == PASS);
        test_fail      = (state == FAIL);
        dbg_state      = state;
        bus.trace_addr = ((state == READ_TRACE) || (state == READ_CACHE)) ? cur_addr : '0;
        bus.dut_rreq   = (state == READ_CACHE);
        bus.dut_raddr  = (state == READ_CACHE) ? cur_addr : '0;
    end

`ifdef GRADER_TIMEOUT_EN
    logic              timeout_q;
    logic              timeout_hit;
    logic [DATA_W-1:0] exp_now;

    assign fail_timeout = timeout_q;
    assign timeout_hit  = (32'(wait_cnt) + 32'd1) == 32'(TIMEOUT_CYC);
    // On the first request cycle the ROM word has not been latched yet.
    assign exp_now      = (wait_cnt == 16'd0) ? bus.trace_rdata : expected;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign fail_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start_ok) begin
            count <= '0;
        end else if (busy && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cur_addr      <= '0;
            last_addr     <= '0;
            expected      <= '0;
            actual        <= '0;
            wait_cnt      <= '0;
            max_latency   <= '0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
`ifdef GRADER_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            case (state)
                READ_TRACE: begin
                    wait_cnt <= '0;
                    state    <= READ_CACHE;
                end
                READ_CACHE: begin
                    if (wait_cnt == 16'd0) expected <= bus.trace_rdata;
                    if (bus.dut_rvalid) begin
                        actual <= bus.dut_rdata;
                        if (latency > max_latency) max_latency <= latency;
                        state  <= COMPARE;
                    end else begin
                        if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
`ifdef GRADER_TIMEOUT_EN
                        if (timeout_hit) begin
                            timeout_q     <= 1'b1;
                            fail_addr     <= cur_addr;
                            fail_expected <= exp_now;
                            fail_actual   <= '0;
                            state         <= FAIL;
                        end
`endif
                    end
                end
                COMPARE: begin
                    if (expected != actual) begin
                        fail_addr     <= cur_addr;
                        fail_expected <= expected;
                        fail_actual   <= actual;
                        state         <= FAIL;
                    end else if (cur_addr == last_addr) begin
                        state <= PASS;
                    end else begin
                        cur_addr <= cur_addr + 1'b1;
                        state    <= READ_TRACE;
                    end
                end
                default: begin
                    // IDLE, PASS, FAIL: a start wipes every trace of the previous run.
                    if (start_ok) begin
                        cur_addr      <= start_addr;
                        last_addr     <= end_addr;
                        expected      <= '0;
                        actual        <= '0;
                        wait_cnt      <= '0;
                        max_latency   <= '0;
                        fail_addr     <= '0;
                        fail_expected <= '0;
                        fail_actual   <= '0;
`ifdef GRADER_TIMEOUT_EN
                        timeout_q     <= 1'b0;
`endif
                        state         <= READ_TRACE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trace_grader.sv
// Directed bench for trace_grader: golden ROM model, configurable cache responder,
// hand-computed expectations. Timeout section follows GRADER_TIMEOUT_EN.
module tb_trace_grader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  start_addr = '0;
    logic [9:0]  end_addr = '0;
    logic        busy, test_success, test_fail, fail_timeout;
    logic [9:0]  fail_addr;
    logic [7:0]  fail_expected, fail_actual;
    logic [31:0] count;
    logic [15:0] max_latency;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    trace_grader_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    trace_grader #(.ADDR_W(10), .DATA_W(8), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .reset(reset), .start(start),
        .start_addr(start_addr), .end_addr(end_addr), .bus(bus),
        .busy(busy), .test_success(test_success), .test_fail(test_fail),
        .fail_timeout(fail_timeout), .fail_addr(fail_addr),
        .fail_expected(fail_expected), .fail_actual(fail_actual),
        .count(count), .max_latency(max_latency), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- golden ROM and cache responder ----------------
    int slow_addr = -1;
    int slow_delay = 1;
    int bad_addr = -1;
    int hang_addr = -1;
    int m_cnt = 0;
    logic [9:0] seen_q[$];

    function automatic logic [7:0] rom_val(input logic [9:0] a);
        if (a == 10'd7) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    always @(posedge clk) bus.trace_rdata <= rom_val(bus.trace_addr);

    always @(posedge clk) begin
        if (!bus.dut_rreq || bus.dut_rvalid) begin
            m_cnt          <= 0;
            bus.dut_rvalid <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if ((int'(bus.dut_raddr) != hang_addr) &&
                (m_cnt + 1 >= ((int'(bus.dut_raddr) == slow_addr) ? slow_delay : 1))) begin
                bus.dut_rvalid <= 1'b1;
                bus.dut_rdata  <= (int'(bus.dut_raddr) == bad_addr) ? 8'h5A : rom_val(bus.dut_raddr);
                seen_q.push_back(bus.dut_raddr);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [9:0] s, input logic [9:0] e);
        @(negedge clk);
        start = 1'b1; start_addr = s; end_addr = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!(test_success || test_fail) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(test_success || test_fail), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [9:0] exp_q[$];

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rreq", 32'(bus.dut_rreq), 32'd0);
        check("rst_taddr", 32'(bus.trace_addr), 32'd0);
        check("rst_count", count, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk); reset = 1'b0;

        // full pass 0..15, one-cycle responder: 4 cycles per access
        do_start(10'd0, 10'd15);
        wait_done(200, "pass");
        check("pass_succ", 32'(test_success), 32'd1);
        check("pass_fail", 32'(test_fail), 32'd0);
        check("pass_count", count, 32'd64);
        check("pass_maxlat", 32'(max_latency), 32'd1);
        check("pass_busy", 32'(busy), 32'd0);

        // mismatch at address 7: 8 accesses before FAIL
        bad_addr = 7;
        do_start(10'd0, 10'd15);
        wait_done(200, "mis");
        check("mis_fail", 32'(test_fail), 32'd1);
        check("mis_succ", 32'(test_success), 32'd0);
        check("mis_addr", 32'(fail_addr), 32'd7);
        check("mis_exp", 32'(fail_expected), 32'hA5);
        check("mis_act", 32'(fail_actual), 32'h5A);
        check("mis_count", count, 32'd32);
        repeat (5) @(negedge clk);
        check("mis_count_frozen", count, 32'd32);
        bad_addr = -1;

        // reset while in FAIL clears capture registers
        pulse_reset();
        check("rstf_fail", 32'(test_fail), 32'd0);
        check("rstf_addr", 32'(fail_addr), 32'd0);
        check("rstf_exp", 32'(fail_expected), 32'd0);
        check("rstf_act", 32'(fail_actual), 32'd0);

        // wrapping range
        seen_q.delete();
        exp_q = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        do_start(10'd1022, 10'd1);
        wait_done(100, "wrap");
        check("wrap_succ", 32'(test_success), 32'd1);
        check("wrap_count", count, 32'd16);
        check("wrap_nacc", seen_q.size(), 32'd4);
        while (exp_q.size() > 0 && seen_q.size() > 0)
            check("wrap_order", 32'(seen_q.pop_front()), 32'(exp_q.pop_front()));

        // one slow access, with an ignored start mid-run
        slow_addr = 5; slow_delay = 9;
        do_start(10'd0, 10'd7);
        repeat (6) @(negedge clk);
        start = 1'b1; start_addr = 10'd100; end_addr = 10'd100;
        @(negedge clk); start = 1'b0;
        wait_done(200, "lat");
        check("lat_succ", 32'(test_success), 32'd1);
        check("lat_max", 32'(max_latency), 32'd9);
        check("lat_count", count, 32'd40);

        // asynchronous reset mid-access
        slow_addr = 0; slow_delay = 20;
        do_start(10'd0, 10'd3);
        repeat (3) @(negedge clk);
        check("mid_rreq", 32'(bus.dut_rreq), 32'd1);
        check("mid_count", count, 32'd3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rreq", 32'(bus.dut_rreq), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", count, 32'd0);
        check("mid_rst_maxlat", 32'(max_latency), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk); reset = 1'b0;
        slow_addr = -1;

        // restart from PASS
        do_start(10'd0, 10'd1);
        wait_done(100, "rs1");
        check("rs1_succ", 32'(test_success), 32'd1);
        do_start(10'd5, 10'd5);
        check("rs2_succ_clr", 32'(test_success), 32'd0);
        check("rs2_busy", 32'(busy), 32'd1);
        check("rs2_taddr", 32'(bus.trace_addr), 32'd5);
        wait_done(100, "rs2");
        check("rs2_succ", 32'(test_success), 32'd1);
        check("rs2_count", count, 32'd4);

        // cache never answers at address 3
        hang_addr = 3;
        do_start(10'd0, 10'd5);
`ifdef GRADER_TIMEOUT_EN
        wait_done(2000, "to");
        check("to_fail", 32'(test_fail), 32'd1);
        check("to_flag", 32'(fail_timeout), 32'd1);
        check("to_addr", 32'(fail_addr), 32'd3);
        check("to_exp", 32'(fail_expected), 32'h3F);
        check("to_act", 32'(fail_actual), 32'd0);
        check("to_count", count, 32'd268);
`else
        repeat (1000) @(negedge clk);
        check("to_busy", 32'(busy), 32'd1);
        check("to_flag", 32'(fail_timeout), 32'd0);
        check("to_raddr", 32'(bus.dut_raddr), 32'd3);
`endif
        hang_addr = -1;
        pulse_reset();

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
